// File: rtl/interval_timer_if.sv
// Signal bundle between the traffic-light FSM (master) and interval_timer (slave).
// TIMER_STATUS_OUT_EN adds the Timer_Busy / Time_Left status outputs.
interface interval_timer_if #(
    parameter int CNT_W = 4
);
    logic             Start_Timer;
    logic [1:0]       Interval_Select;
    logic             Prog_Sync;
    logic [1:0]       Time_Param_Select;
    logic [CNT_W-1:0] Time_Value;
    logic             Expired;
`ifdef TIMER_STATUS_OUT_EN
    logic             Timer_Busy;
    logic [CNT_W-1:0] Time_Left;
`endif

    modport master (
`ifdef TIMER_STATUS_OUT_EN
        input  Timer_Busy, Time_Left,
`endif
        output Start_Timer, Interval_Select, Prog_Sync, Time_Param_Select, Time_Value,
        input  Expired
    );

    modport slave (
`ifdef TIMER_STATUS_OUT_EN
        output Timer_Busy, Time_Left,
`endif
        input  Start_Timer, Interval_Select, Prog_Sync, Time_Param_Select, Time_Value,
        output Expired
    );
endinterface

// File: rtl/interval_timer.sv
// Seconds countdown timer feeding the traffic-light FSM its Expired event.
// Holds three programmable intervals (base/ext/yel); a prescaler divides the
// clock into 1 s ticks. Optional status outputs under TIMER_STATUS_OUT_EN.
//
// state   | meaning
// BOOT    | first cycle after reset; issue the kick-start Expired pulse
// IDLE    | counter and prescaler hold, waiting for Start_Timer
// RUNNING | prescaler ticking, seconds counter counting down
module interval_timer #(
    parameter int TICK_DIV     = 100000000,
    parameter int CNT_W        = 4,
    parameter int BASE_DEFAULT = 6,
    parameter int EXT_DEFAULT  = 3,
    parameter int YEL_DEFAULT  = 2
) (
    input  logic         clock,
    input  logic         reset,
    interval_timer_if.slave tif
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {BOOT, IDLE, RUNNING} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             expired_q, expired_d;
    logic [CNT_W-1:0] base_q, base_d;
    logic [CNT_W-1:0] ext_q, ext_d;
    logic [CNT_W-1:0] yel_q, yel_d;
    logic [CNT_W-1:0] sel_val;

    // Next-state: programming, start/restart, boot pulse and countdown.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        expired_d = 1'b0;
        base_d    = base_q;
        ext_d     = ext_q;
        yel_d     = yel_q;

        // Start always reads the pre-write register value, so a same-edge
        // write only takes effect from the next start.
        case (tif.Interval_Select)
            2'b01:   sel_val = ext_q;
            2'b10:   sel_val = yel_q;
            default: sel_val = base_q;
        endcase

        if (tif.Prog_Sync) begin
            case (tif.Time_Param_Select)
                2'b00:   base_d = tif.Time_Value;
                2'b01:   ext_d  = tif.Time_Value;
                2'b10:   yel_d  = tif.Time_Value;
                default: ;
            endcase
        end

        if (tif.Start_Timer) begin
            cnt_d   = (sel_val == '0) ? CNT_W'(1) : sel_val;
            presc_d = '0;
            state_d = RUNNING;
        end else begin
            case (state_q)
                BOOT: begin
                    expired_d = 1'b1;
                    state_d   = IDLE;
                end
                IDLE: ;
                RUNNING: begin
                    if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        if (cnt_q > CNT_W'(1)) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            cnt_d     = '0;
                            expired_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous reset to boot state and defaults.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= BOOT;
            cnt_q     <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
            base_q    <= CNT_W'(BASE_DEFAULT);
            ext_q     <= CNT_W'(EXT_DEFAULT);
            yel_q     <= CNT_W'(YEL_DEFAULT);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
            base_q    <= base_d;
            ext_q     <= ext_d;
            yel_q     <= yel_d;
        end
    end

    assign tif.Expired = expired_q;

`ifdef TIMER_STATUS_OUT_EN
    assign tif.Timer_Busy = (state_q == RUNNING);
    assign tif.Time_Left  = (state_q == RUNNING) ? cnt_q : '0;
`endif
endmodule
